// File: rtl/rcv_pkg.sv
// Shared types and constants for the serial receive control path.
package rcv_pkg;

    localparam int unsigned RCV_DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        RECV,
        CHECK,
        LOAD
    } rcv_state_t;

    // The timer only paces bits while a packet body is being received.
    function automatic logic state_runs_timer(input rcv_state_t s);
        return (s == RECV);
    endfunction

endpackage

// File: rtl/rcv_buffer.sv
// Output buffer for received packets: holds the payload, the unread flag and overrun status.
module rcv_buffer
    import rcv_pkg::*;
#(
    parameter int unsigned DATA_BITS = RCV_DATA_BITS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic [DATA_BITS-1:0] packet_data,
    input  logic                 data_read,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 data_ready,
    output logic                 overrun_error
);

    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 ready_q, ready_d;
    logic                 overrun_q, overrun_d;

    always_comb begin
        rx_data_d = rx_data_q;
        ready_d   = ready_q;
        overrun_d = overrun_q;
        if (load) begin
            // A concurrent read consumes the old packet, so only an unread one overruns.
            rx_data_d = packet_data;
            ready_d   = 1'b1;
            overrun_d = ready_q & ~data_read;
        end else if (data_read && ready_q) begin
            ready_d   = 1'b0;
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_data_q <= '0;
            ready_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            rx_data_q <= rx_data_d;
            ready_q   <= ready_d;
            overrun_q <= overrun_d;
        end
    end

    assign rx_data       = rx_data_q;
    assign data_ready    = ready_q;
    assign overrun_error = overrun_q;

endmodule

// File: rtl/rcv_ctrl.sv
// Receiver control: sequences a packet around the timer, checks the stop bit, feeds the buffer.
module rcv_ctrl
    import rcv_pkg::*;
#(
    parameter int unsigned DATA_BITS = RCV_DATA_BITS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_bit_detected,
    input  logic                 packet_done,
    input  logic                 stop_bit,
    input  logic [DATA_BITS-1:0] packet_data,
    input  logic                 data_read,
    output logic                 enable_timer,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 data_ready,
    output logic                 overrun_error,
    output logic                 framing_error
);

    rcv_state_t state_q, state_d;
    logic       framing_q, framing_d;
    logic       load;

    always_comb begin
        state_d   = state_q;
        framing_d = framing_q;
        unique case (state_q)
            IDLE: begin
                if (start_bit_detected) begin
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                framing_d = 1'b0;
                state_d   = RECV;
            end
            RECV: begin
                if (packet_done) begin
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (stop_bit) begin
                    state_d = LOAD;
                end else begin
                    framing_d = 1'b1;
                    state_d   = IDLE;
                end
            end
            LOAD: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            framing_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            framing_q <= framing_d;
        end
    end

    assign enable_timer  = state_runs_timer(state_q);
    assign load          = (state_q == LOAD);
    assign framing_error = framing_q;

    rcv_buffer #(
        .DATA_BITS (DATA_BITS)
    ) u_buffer (
        .clk           (clk),
        .rst           (rst),
        .load          (load),
        .packet_data   (packet_data),
        .data_read     (data_read),
        .rx_data       (rx_data),
        .data_ready    (data_ready),
        .overrun_error (overrun_error)
    );

endmodule

// File: tb/tb_rcv_ctrl.sv
// Directed and randomized checks of rcv_ctrl against a packet-level reference model.
module tb_rcv_ctrl;

    logic       clk;
    logic       rst;
    logic       start_bit_detected;
    logic       packet_done;
    logic       stop_bit;
    logic [7:0] packet_data;
    logic       data_read;
    logic       enable_timer;
    logic [7:0] rx_data;
    logic       data_ready;
    logic       overrun_error;
    logic       framing_error;

    int total = 0;
    int bad   = 0;

    // Reference model of the consumer-visible state
    logic [7:0] m_rx;
    logic       m_ready;
    logic       m_ovr;
    logic       m_fe;

    rcv_ctrl #(
        .DATA_BITS (8)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .start_bit_detected (start_bit_detected),
        .packet_done        (packet_done),
        .stop_bit           (stop_bit),
        .packet_data        (packet_data),
        .data_read          (data_read),
        .enable_timer       (enable_timer),
        .rx_data            (rx_data),
        .data_ready         (data_ready),
        .overrun_error      (overrun_error),
        .framing_error      (framing_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, "_rx"},    {24'd0, rx_data}, {24'd0, m_rx});
        chk({tag, "_ready"}, {31'd0, data_ready}, {31'd0, m_ready});
        chk({tag, "_ovr"},   {31'd0, overrun_error}, {31'd0, m_ovr});
        chk({tag, "_fe"},    {31'd0, framing_error}, {31'd0, m_fe});
        chk({tag, "_en"},    {31'd0, enable_timer}, 32'd0);
    endtask

    // One packet: start pulse, len cycles of timer enable, packet_done, then check/load.
    task automatic run_packet(input string tag, input int len, input logic stp,
                              input logic [7:0] d, input logic rd_load, input logic stray);
        int hi;
        start_bit_detected = 1'b1;
        tick();
        start_bit_detected = 1'b0;
        chk({tag, "_clear_en"}, {31'd0, enable_timer}, 32'd0);
        hi = 0;
        for (int i = 0; i < len; i++) begin
            if (stray && i == len / 2) start_bit_detected = 1'b1;
            tick();
            start_bit_detected = 1'b0;
            if (enable_timer) hi++;
            if (i == 0) begin
                m_fe = 1'b0;
                chk({tag, "_fe_cleared"}, {31'd0, framing_error}, 32'd0);
            end
        end
        packet_done = 1'b1;
        stop_bit    = stp;
        packet_data = d;
        tick();
        packet_done = 1'b0;
        if (enable_timer) hi++;
        chk({tag, "_en_cycles"}, hi, len);
        chk({tag, "_check_rx"}, {24'd0, rx_data}, {24'd0, m_rx});
        tick();
        if (!stp) m_fe = 1'b1;
        chk({tag, "_fe_at_load"}, {31'd0, framing_error}, {31'd0, m_fe});
        chk({tag, "_ready_lat"}, {31'd0, data_ready}, {31'd0, m_ready});
        chk({tag, "_rx_lat"}, {24'd0, rx_data}, {24'd0, m_rx});
        data_read = rd_load;
        tick();
        data_read = 1'b0;
        if (stp) begin
            if (rd_load)      m_ovr = 1'b0;
            else if (m_ready) m_ovr = 1'b1;
            m_ready = 1'b1;
            m_rx    = d;
        end else if (rd_load && m_ready) begin
            m_ready = 1'b0;
            m_ovr   = 1'b0;
        end
        packet_data = 8'($urandom);
        chk_all(tag);
    endtask

    // Idle gap, optionally with a consumer read and a stray packet_done in the first cycle.
    task automatic gap(input string tag, input int n, input logic rd, input logic stray_pd);
        for (int i = 0; i < n; i++) begin
            data_read   = rd && (i == 0);
            packet_done = stray_pd && (i == 0);
            stop_bit    = 1'b1;
            tick();
            data_read   = 1'b0;
            packet_done = 1'b0;
            if (i == 0 && rd && m_ready) begin
                m_ready = 1'b0;
                m_ovr   = 1'b0;
            end
            if (i == 0) chk_all({tag, "_first"});
        end
        chk_all(tag);
    endtask

    initial begin
        rst = 1'b1;
        start_bit_detected = 1'b0;
        packet_done = 1'b0;
        stop_bit = 1'b1;
        packet_data = 8'h00;
        data_read = 1'b0;
        m_rx = 8'h00; m_ready = 1'b0; m_ovr = 1'b0; m_fe = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        chk_all("reset");

        run_packet("good", 90, 1'b1, 8'hA5, 1'b0, 1'b0);
        gap("good_gap", 3, 1'b0, 1'b0);
        run_packet("frame", 90, 1'b0, 8'h3C, 1'b0, 1'b0);
        gap("frame_gap", 2, 1'b0, 1'b0);
        run_packet("frame2", 5, 1'b0, 8'h99, 1'b0, 1'b0);
        gap("read_a5", 2, 1'b1, 1'b0);

        run_packet("ovr1", 12, 1'b1, 8'h11, 1'b0, 1'b0);
        run_packet("ovr2", 12, 1'b1, 8'h22, 1'b0, 1'b0);
        gap("ovr_read", 2, 1'b1, 1'b0);
        gap("read_empty", 2, 1'b1, 1'b0);

        run_packet("sim55", 8, 1'b1, 8'h55, 1'b0, 1'b0);
        run_packet("sim77", 8, 1'b1, 8'h77, 1'b1, 1'b0);

        gap("stray_pd", 3, 1'b0, 1'b1);
        run_packet("stray_st", 90, 1'b1, 8'hC3, 1'b0, 1'b1);

        // Reset in the middle of a packet body
        start_bit_detected = 1'b1;
        tick();
        start_bit_detected = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        chk("mid_recv_en", {31'd0, enable_timer}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m_rx = 8'h00; m_ready = 1'b0; m_ovr = 1'b0; m_fe = 1'b0;
        chk_all("rst_mid");
        gap("rst_idle", 4, 1'b0, 1'b1);

        for (int p = 0; p < 25; p++) begin
            logic stp;
            logic rdl;
            stp = ($urandom_range(0, 3) != 0);
            rdl = ($urandom_range(0, 3) == 0);
            run_packet("rnd", int'($urandom_range(2, 20)), stp, 8'($urandom), rdl,
                       $urandom_range(0, 1) == 1);
            if ($urandom_range(0, 2) != 0) begin
                gap("rnd_gap", int'($urandom_range(1, 4)), $urandom_range(0, 2) == 0,
                    $urandom_range(0, 1) == 1);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rcv_ctrl.md
# rcv_ctrl

- Receiver control unit for the serial receive path, sitting directly upstream of the `timer` block.
- Starts a packet on a start-bit detection and drives `enable_timer` while the timer paces the bits.
- On the timer's `packet_done` pulse it checks the stop bit and either latches the shifted data into an output buffer or flags a framing error.
- Owns the `data_ready`/`data_read` handshake and overrun reporting toward the consumer.

## Interface

Parameters:
- `DATA_BITS`, default 8: payload width per packet.

Ports:
- `clk`  in  1: single clock; all state changes on the rising edge.
- `rst`  in  1: reset, synchronous, active-high.
- `start_bit_detected`  in  1: one-cycle pulse from the start-bit detector.
- `packet_done`  in  1: one-cycle pulse from `timer` after the stop bit has been sampled.
- `stop_bit`  in  1: sampled stop bit from the shift register.
- `packet_data`  in  `DATA_BITS`: parallel payload from the shift register.
- `data_read`  in  1: consumer acknowledge, level-sampled.
- `enable_timer`  out  1: timer run enable.
- `rx_data`  out  `DATA_BITS`: buffered payload.
- `data_ready`  out  1: `rx_data` holds an unread packet.
- `overrun_error`  out  1: a packet overwrote unread data.
- `framing_error`  out  1: the last packet had stop bit = 0.

## Operation

State machine (Moore outputs decoded from the state register):
- IDLE: `enable_timer`=0. `start_bit_detected` → CLEAR; otherwise stay.
- CLEAR: one cycle. `framing_error` is cleared at the exiting edge. → RECV.
- RECV: `enable_timer`=1. `packet_done` → CHECK; otherwise stay.
- CHECK: one cycle, `enable_timer`=0.
  - `stop_bit`=1 → LOAD.
  - `stop_bit`=0 → set `framing_error` and go to IDLE; the buffer is untouched.
- LOAD: one cycle.
  - `rx_data` ← `packet_data`; `data_ready` ← 1.
  - If `data_ready` was already 1 and `data_read`=0 this cycle, set `overrun_error`.
  - → IDLE.

Buffer handshake:
- `data_read`=1 while `data_ready`=1 clears `data_ready` and `overrun_error` at the next edge.
- `data_read` while `data_ready`=0 is ignored.
- `data_read` and LOAD in the same cycle: the load wins. `data_ready` stays 1, `overrun_error` is cleared, and `rx_data` takes the new value.

Boundary conditions:
- `start_bit_detected` outside IDLE is ignored.
- `packet_done` outside RECV is ignored.
- `framing_error` is sticky until the next CLEAR or reset; it is independent of `data_ready`.
- Back-to-back packets: a start pulse in the cycle after LOAD (state IDLE) is accepted.
- Unread data persists across any number of framing-error packets.

## Timing

- Reset (synchronous, `rst`=1 at an edge): state=IDLE; `enable_timer`, `data_ready`, `overrun_error` and `framing_error` are 0; `rx_data` is all zeros. This holds mid-packet as well.
- `start_bit_detected` sampled at edge k:
  - CLEAR after edge k.
  - `enable_timer`=1 from edge k+1 until the edge that samples `packet_done`.
- `packet_done` sampled at edge m:
  - CHECK during m..m+1.
  - `framing_error` or LOAD state visible after m+1.
  - `data_ready`/`rx_data` valid after m+2.
- `data_read` sampled at edge r: `data_ready` low after r.
- All outputs are registered or state-decoded; there is no combinational input→output path.

## Structure

- Package `rcv_pkg`:
  - enum `rcv_state_t` {IDLE, CLEAR, RECV, CHECK, LOAD}.
  - `RCV_DATA_BITS` = 8, the default source for `DATA_BITS`.
- Sub-module `rcv_buffer`: holds `rx_data`, `data_ready` and `overrun_error`, driven by a `load` strobe from the FSM and by `data_read`.
- The FSM and `framing_error` stay in `rcv_ctrl`.

## Test plan

- Reset mid-RECV (`rst`=1 one edge) → `enable_timer`=0, all flags 0, `rx_data`=0x00, state IDLE.
- Good packet:
  - Stimulus: start pulse, `packet_done` 90 cycles later, `stop_bit`=1, `packet_data`=0xA5.
  - Required: `enable_timer` high for exactly 90 cycles; `rx_data`=0xA5 and `data_ready`=1 two cycles after `packet_done`; `framing_error`=0.
- Framing error:
  - Stimulus: as above with `stop_bit`=0, `packet_data`=0x3C.
  - Required: `framing_error`=1; `data_ready` and `rx_data` unchanged; the next start pulse clears `framing_error` one cycle later.
- Overrun:
  - Stimulus: two good packets (0x11, then 0x22) with no `data_read`.
  - Required: `rx_data`=0x22, `overrun_error`=1; then `data_read`=1 for one cycle → `data_ready`=0 and `overrun_error`=0.
- Simultaneous events:
  - Stimulus: `data_read` asserted in the LOAD cycle of packet 0x77 while 0x55 is unread.
  - Required: `rx_data`=0x77, `data_ready`=1, `overrun_error`=0.
- Stray pulses:
  - Stimulus: `start_bit_detected` during RECV; `packet_done` during IDLE.
  - Required: no state change; `enable_timer` timing as in the good-packet case.
